// File: rtl/mems_mics_pingpong_buffer.sv
// Ping-pong capture buffer for multichannel MEMS mic frames: two RAM banks fill alternately
// from an Avalon-ST source; the completed bank and CSRs are read over a 2-cycle Avalon-MM slave.
module mems_mics_pingpong_buffer #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned DEPTH    = 128
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           asi_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]                     asi_data,
  input  logic [$clog2(DEPTH)+$clog2(NUM_CH):0]          avs_address,
  input  logic                                           avs_read,
  input  logic                                           avs_write,
  input  logic [SAMPLE_W-1:0]                            avs_writedata,
  output logic [SAMPLE_W-1:0]                            avs_readdata,
  output logic                                           avs_readdatavalid,
  output logic                                           ins_irq
);

  localparam int unsigned FW = NUM_CH * SAMPLE_W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned LW = AW + CW;

  // Capture / handoff state
  logic          fill_bank_q, fill_bank_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic          ready_valid_q, ready_valid_d;
  logic          ready_bank_q, ready_bank_d;
  logic          hold_q, hold_d;
  logic [15:0]   ovf_cnt_q, ovf_cnt_d;

  // Address decode
  logic          csr_sel;
  logic [LW-1:0] word_addr;
  logic [AW-1:0] rd_frame;
  logic [CW-1:0] rd_ch;
  logic          ctrl_wr;
  logic          release_req;
  logic          ovf_clr;
  logic          cap_we;
  logic          last_frame;
  logic          unused_wdata;

  assign csr_sel      = ~avs_address[LW];
  assign word_addr    = avs_address[LW-1:0];
  assign rd_frame     = avs_address[LW-1:CW];
  assign rd_ch        = avs_address[CW-1:0];
  assign ctrl_wr      = avs_write && csr_sel && (word_addr == LW'(1));
  assign release_req  = ctrl_wr && avs_writedata[0] && ready_valid_q;
  assign ovf_clr      = ctrl_wr && avs_writedata[1];
  assign cap_we       = asi_valid && !hold_q;
  assign last_frame   = (fill_ptr_q == AW'(DEPTH - 1));
  assign unused_wdata = ^avs_writedata[SAMPLE_W-1:2];

  always_comb begin
    fill_bank_d   = fill_bank_q;
    fill_ptr_d    = fill_ptr_q;
    ready_valid_d = ready_valid_q;
    ready_bank_d  = ready_bank_q;
    hold_d        = hold_q;
    ovf_cnt_d     = ovf_cnt_q;

    if (hold_q) begin
      if (asi_valid && (ovf_cnt_q != 16'hFFFF)) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
      if (release_req) begin
        ready_bank_d = fill_bank_q;
        fill_bank_d  = ~fill_bank_q;
        hold_d       = 1'b0;
      end
    end else begin
      if (release_req) begin
        ready_valid_d = 1'b0;
      end
      if (cap_we) begin
        fill_ptr_d = fill_ptr_q + 1'b1;
        // A completed bank is handed off only if the reader has freed the other one
        if (last_frame) begin
          if (!ready_valid_q || release_req) begin
            ready_bank_d  = fill_bank_q;
            ready_valid_d = 1'b1;
            fill_bank_d   = ~fill_bank_q;
          end else begin
            hold_d = 1'b1;
          end
        end
      end
    end

    if (ovf_clr) begin
      ovf_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_bank_q   <= 1'b0;
      fill_ptr_q    <= '0;
      ready_valid_q <= 1'b0;
      ready_bank_q  <= 1'b0;
      hold_q        <= 1'b0;
      ovf_cnt_q     <= 16'd0;
    end else begin
      fill_bank_q   <= fill_bank_d;
      fill_ptr_q    <= fill_ptr_d;
      ready_valid_q <= ready_valid_d;
      ready_bank_q  <= ready_bank_d;
      hold_q        <= hold_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

  // Frame RAM: one capture write port, one synchronous read port on the opposite bank
  logic [FW-1:0] mem [2*DEPTH];
  logic [FW-1:0] ram_q;

  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem[{fill_bank_q, fill_ptr_q}] <= asi_data;
    end
    if (avs_read) begin
      ram_q <= mem[{ready_bank_q, rd_frame}];
    end
  end

  // CSR read data, evaluated at issue so it reflects pre-write state
  logic [31:0]         status_word;
  logic [31:0]         config_word;
  logic [SAMPLE_W-1:0] csr_rdata;

  assign status_word = {ovf_cnt_q, 13'd0, hold_q, ready_bank_q, ready_valid_q};
  assign config_word = {16'd0, 8'(AW), 8'(CW)};

  always_comb begin
    csr_rdata = '0;
    if (word_addr == LW'(0)) begin
      csr_rdata = status_word[SAMPLE_W-1:0];
    end else if (word_addr == LW'(2)) begin
      csr_rdata = config_word[SAMPLE_W-1:0];
    end
  end

  // Read pipeline stage 1
  logic                rd_p1_q;
  logic                rd_data_q;
  logic [CW-1:0]       rd_ch_q;
  logic [SAMPLE_W-1:0] csr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_p1_q   <= 1'b0;
      rd_data_q <= 1'b0;
      rd_ch_q   <= '0;
      csr_q     <= '0;
    end else begin
      rd_p1_q <= avs_read;
      if (avs_read) begin
        rd_data_q <= !csr_sel && ready_valid_q;
        rd_ch_q   <= rd_ch;
        csr_q     <= csr_sel ? csr_rdata : '0;
      end
    end
  end

  // Read pipeline stage 2 and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      ins_irq           <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_p1_q;
      ins_irq           <= ready_valid_q;
      if (rd_p1_q) begin
        avs_readdata <= rd_data_q ? ram_q[rd_ch_q*SAMPLE_W +: SAMPLE_W] : csr_q;
      end
    end
  end

endmodule

// File: tb/tb_mems_mics_pingpong_buffer.sv
// Directed self-checking bench for mems_mics_pingpong_buffer at default parameters.
module tb_mems_mics_pingpong_buffer;

  localparam int ADW = 11;

  logic           clk;
  logic           reset_n;
  logic           asi_valid;
  logic [255:0]   asi_data;
  logic [ADW-1:0] avs_address;
  logic           avs_read;
  logic           avs_write;
  logic [31:0]    avs_writedata;
  logic [31:0]    avs_readdata;
  logic           avs_readdatavalid;
  logic           ins_irq;

  int checks;
  int failures;

  mems_mics_pingpong_buffer #(
    .NUM_CH  (8),
    .SAMPLE_W(32),
    .DEPTH   (128)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .asi_valid        (asi_valid),
    .asi_data         (asi_data),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .ins_irq          (ins_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] frame_data(input int g);
    logic [255:0] d;
    logic [31:0]  gv;
    logic [31:0]  cv;
    gv = g;
    for (int c = 0; c < 8; c++) begin
      cv = c;
      d[c*32 +: 32] = {gv[15:0], cv[15:0]};
    end
    return d;
  endfunction

  function automatic logic [ADW-1:0] daddr(input int f, input int c);
    logic [31:0] fv;
    logic [31:0] cv;
    fv = f;
    cv = c;
    return {1'b1, fv[6:0], cv[2:0]};
  endfunction

  task automatic send_frames(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      asi_valid = 1'b1;
      asi_data  = frame_data(first + i);
      tick();
    end
    asi_valid = 1'b0;
  endtask

  task automatic csr_write(input logic [ADW-1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  // Issue one read and wait (bounded) for its result; lat counts cycles from issue
  task automatic do_read(input logic [ADW-1:0] a, output logic [31:0] d, output int lat);
    avs_address = a;
    avs_read    = 1'b1;
    tick();
    avs_read = 1'b0;
    lat      = 1;
    while (!avs_readdatavalid && lat < 6) begin
      tick();
      lat++;
    end
    d = avs_readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    reset_n = 1'b0; asi_valid = 1'b0; asi_data = '0; avs_address = '0;
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    #12;
    checks++;
    if ({avs_readdata, avs_readdatavalid, ins_irq} !== 34'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", {avs_readdata, avs_readdatavalid, ins_irq});
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_status: got %h required 0", d); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL reset_latency: got %0d required 2", lat); end
    do_read(11'd2, d, lat);
    checks++;
    if (d !== 32'h0000_0703) begin failures++; $display("FAIL config: got %h required 00000703", d); end
    do_read(11'd1, d, lat);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL control_read: got %h required 0", d); end
  endtask

  task automatic test_first_fill();
    logic [31:0] d;
    int lat;
    send_frames(0, 128);
    checks++;
    if (ins_irq !== 1'b0) begin failures++; $display("FAIL irq_early: got %b required 0", ins_irq); end
    tick();
    checks++;
    if (ins_irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b required 1", ins_irq); end
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h0000_0001) begin failures++; $display("FAIL fill_status: got %h required 00000001", d); end
    do_read(daddr(5, 3), d, lat);
    checks++;
    if (d !== 32'h0005_0003) begin failures++; $display("FAIL data_5_3: got %h required 00050003", d); end
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL data_latency: got %0d required 2", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int k = 0; k < 12; k++) begin
      avs_read    = (k < 8);
      avs_address = daddr(10, k % 8);
      tick();
      checks++;
      if (avs_readdatavalid !== (k >= 1 && k <= 8)) begin
        failures++;
        $display("FAIL b2b_valid[%0d]: got %b required %b", k, avs_readdatavalid, (k >= 1 && k <= 8));
      end
      if (k >= 1 && k <= 8) begin
        exp = {16'd10, 16'(k - 1)};
        checks++;
        if (avs_readdata !== exp) begin
          failures++;
          $display("FAIL b2b_data[%0d]: got %h required %h", k - 1, avs_readdata, exp);
        end
      end
    end
    avs_read = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int lat;
    send_frames(128, 128);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h0000_0005) begin failures++; $display("FAIL hold_status: got %h required 00000005", d); end
    send_frames(256, 10);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0005) begin failures++; $display("FAIL ovf_status: got %h required 000A0005", d); end
    do_read(daddr(127, 7), d, lat);
    checks++;
    if (d !== 32'h007F_0007) begin failures++; $display("FAIL hold_data: got %h required 007F0007", d); end
    csr_write(11'd1, 32'h1);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0003) begin failures++; $display("FAIL rel_status: got %h required 000A0003", d); end
    checks++;
    if (ins_irq !== 1'b1) begin failures++; $display("FAIL rel_irq: got %b required 1", ins_irq); end
    do_read(daddr(0, 2), d, lat);
    checks++;
    if (d !== 32'h0080_0002) begin failures++; $display("FAIL bank1_data: got %h required 00800002", d); end
    send_frames(400, 128);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0007) begin failures++; $display("FAIL hold2_status: got %h required 000A0007", d); end
    csr_write(11'd1, 32'h1);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0001) begin failures++; $display("FAIL rel2_status: got %h required 000A0001", d); end
    do_read(daddr(3, 1), d, lat);
    checks++;
    if (d !== 32'h0193_0001) begin failures++; $display("FAIL bank0_data: got %h required 01930001", d); end
  endtask

  task automatic test_release_on_last();
    logic [31:0] d;
    int lat;
    send_frames(600, 127);
    asi_valid = 1'b1; asi_data = frame_data(727);
    avs_address = 11'd1; avs_writedata = 32'h1; avs_write = 1'b1;
    tick();
    asi_valid = 1'b0; avs_write = 1'b0;
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0003) begin failures++; $display("FAIL last_rel_status: got %h required 000A0003", d); end
    do_read(daddr(127, 0), d, lat);
    checks++;
    if (d !== 32'h02D7_0000) begin failures++; $display("FAIL last_rel_d127: got %h required 02D70000", d); end
    do_read(daddr(0, 5), d, lat);
    checks++;
    if (d !== 32'h0258_0005) begin failures++; $display("FAIL last_rel_d0: got %h required 02580005", d); end
  endtask

  task automatic test_read_release();
    logic [31:0] d;
    int lat;
    avs_address = daddr(127, 0); avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    csr_write(11'd1, 32'h1);
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h02D7_0000) begin
      failures++;
      $display("FAIL read_at_release: got v=%b %h required v=1 02D70000", avs_readdatavalid, avs_readdata);
    end
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0002) begin failures++; $display("FAIL freed_status: got %h required 000A0002", d); end
    do_read(daddr(5, 5), d, lat);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL empty_read: got %h required 0", d); end
    csr_write(11'd1, 32'h1);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h000A_0002) begin failures++; $display("FAIL idle_release: got %h required 000A0002", d); end
    // Read and ovf-clear write together: both take effect
    avs_address = 11'd1; avs_writedata = 32'h2; avs_write = 1'b1; avs_read = 1'b1;
    tick();
    avs_write = 1'b0; avs_read = 1'b0;
    tick();
    checks++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h0) begin
      failures++;
      $display("FAIL rw_same_cycle: got v=%b %h required v=1 0", avs_readdatavalid, avs_readdata);
    end
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h0000_0002) begin failures++; $display("FAIL ovf_clear: got %h required 00000002", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat;
    int vcount;
    send_frames(800, 128);
    tick();
    send_frames(928, 60);
    do_read(daddr(1, 1), d, lat);
    checks++;
    if (d !== 32'h0321_0001 || ins_irq !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got %h irq=%b required 03210001 irq=1", d, ins_irq);
    end
    avs_address = daddr(2, 2); avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({avs_readdata, avs_readdatavalid, ins_irq} !== 34'd0) begin
      failures++;
      $display("FAIL async_reset: got %h required 0", {avs_readdata, avs_readdatavalid, ins_irq});
    end
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (avs_readdatavalid) vcount++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    if (avs_readdatavalid) vcount++;
    checks++;
    if (vcount !== 0) begin failures++; $display("FAIL aborted_read: got %0d valids required 0", vcount); end
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL post_reset_status: got %h required 0", d); end
    send_frames(1000, 128);
    do_read(11'd0, d, lat);
    checks++;
    if (d !== 32'h0000_0001) begin failures++; $display("FAIL refill_status: got %h required 00000001", d); end
    do_read(daddr(0, 0), d, lat);
    checks++;
    if (d !== 32'h03E8_0000) begin failures++; $display("FAIL refill_d0: got %h required 03E80000", d); end
    do_read(daddr(127, 7), d, lat);
    checks++;
    if (d !== 32'h0467_0007) begin failures++; $display("FAIL refill_d127: got %h required 04670007", d); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_fill();
    test_back_to_back();
    test_overflow();
    test_release_on_last();
    test_read_release();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
